// File: rtl/glitch_report_pkg.sv
// Shared types and constants for the glitch result reporter.
// Entry layout, packet header byte and flag-byte bit positions.
package glitch_report_pkg;

    localparam logic [7:0] HEADER_BYTE  = 8'hA5;
    localparam int         MISMATCH_BIT = 0;
    localparam int         OVF_BIT      = 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        FLAG
    } state_e;

    typedef struct packed {
        logic       mismatch;
        logic [7:0] value;
    } entry_t;

    function automatic logic [7:0] flag_byte(input logic ovf,
                                             input logic mm);
        logic [7:0] b;
        b               = 8'h00;
        b[OVF_BIT]      = ovf;
        b[MISMATCH_BIT] = mm;
        return b;
    endfunction

endpackage

// File: rtl/report_fifo.sv
// Single-clock FIFO with level counter; level is the full/empty authority.
// A pop frees a slot for a push in the same cycle when full.
module report_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [8:0],
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  T            wdata_i,
    output T            rdata_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] level_o
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/glitch_result_reporter.sv
// Classifies pipeline results, buffers them and frames 3-byte report packets.
// Optional FAULT_COUNT_EN adds a saturating mismatch counter port.
module glitch_result_reporter
    import glitch_report_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] HEADER     = HEADER_BYTE
) (
    input  logic                          glitched_clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              finout,
    input  logic                          DV_3,
    input  logic [WIDTH-1:0]              exp_val,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FAULT_COUNT_EN
    ,
    output logic [15:0]                   fault_cnt
`endif
);

    state_e state_q, state_d;
    entry_t hold_q, hold_d;
    logic   hold_ovf_q, hold_ovf_d;
    logic   overflow_q, overflow_d;
    entry_t push_entry;
    entry_t fifo_rdata;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   mismatch;

    assign mismatch   = (finout != exp_val);
    assign push_entry = '{mismatch: mismatch, value: finout};
    assign overflow   = overflow_q;
    // A push on a full FIFO survives only if the engine pops this cycle.
    assign overflow_d = overflow_q | (DV_3 && fifo_full && !pop);

    report_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk_i   (glitched_clk),
        .rst_ni  (rst),
        .push_i  (DV_3),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_ovf_d = hold_ovf_q;
        pop        = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    hold_d     = fifo_rdata;
                    hold_ovf_d = overflow_q;
                    state_d    = HDR;
                end
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) state_d = DATA;
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = hold_q.value;
                if (tx_ready) state_d = FLAG;
            end
            FLAG: begin
                tx_valid = 1'b1;
                tx_data  = flag_byte(hold_ovf_q, hold_q.mismatch);
                if (tx_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            hold_ovf_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_ovf_q <= hold_ovf_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef FAULT_COUNT_EN
    logic [15:0] fault_q, fault_d;

    always_comb begin
        fault_d = fault_q;
        if (DV_3 && mismatch && (fault_q != 16'hFFFF)) begin
            fault_d = fault_q + 16'd1;
        end
    end

    always_ff @(posedge glitched_clk) begin
        if (!rst) begin
            fault_q <= 16'h0000;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault_cnt = fault_q;
`endif

endmodule
